gups_update_engine: RTL and testbench



---
 rtl/gups_pkg.sv | 29 ++
 rtl/gups_lfsr16.sv | 23 ++
 rtl/gups_update_engine.sv | 181 ++++++++++++++++++
 tb/tb_gups_update_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gups_pkg.sv
// Shared types, constants and LFSR helpers for the GUPS read-modify-write engine.
package gups_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam logic [1:0] MODE_INC = 2'd0;
    localparam logic [1:0] MODE_XOR = 2'd1;
    localparam logic [1:0] MODE_ADD = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MOD,
        WR,
        NEXT,
        DONE
    } state_t;

    // An all-zero Galois LFSR is stuck, so a zero seed is replaced by 1.
    function automatic logic [LFSR_W-1:0] lfsr_fix_seed(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/gups_lfsr16.sv
// One 16-bit Galois LFSR lane: loadable seed, single-step advance.
module gups_lfsr16
    import gups_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= lfsr_fix_seed(seed);
        end else if (step) begin
            value <= lfsr_advance(value);
        end
    end

endmodule

// File: rtl/gups_update_engine.sv
// Random-address read-modify-write engine driving a req/wr/rdy memory port.
module gups_update_engine
    import gups_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 64,
    parameter int unsigned NUM_LFSR = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [CNT_W-1:0]           num_updates,
    input  logic [LFSR_W*NUM_LFSR-1:0] seed,
    input  logic [ADDR_W-1:0]          range,
    output logic [ADDR_W-1:0]          addr,
    output logic [DATA_W-1:0]          dout,
    input  logic [DATA_W-1:0]          din,
    output logic                       req,
    output logic                       wr,
    input  logic                       rdy,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           upd_count
);

    localparam int unsigned RND_W = LFSR_W * NUM_LFSR;

    state_t             state, state_next;
    logic [RND_W-1:0]   rnd, seed_fix;
    logic               lane_load, lane_step;
    logic [1:0]         mode_q, mode_n;
    logic [CNT_W-1:0]   num_q, num_n, cnt_n;
    logic [ADDR_W-1:0]  range_q, range_n, addr_n;
    logic [DATA_W-1:0]  din_q, din_n, dout_n, rnd_d;
    logic               req_n, wr_n, busy_n, done_n;

    for (genvar g = 0; g < NUM_LFSR; g++) begin : g_lane
        gups_lfsr16 u_lfsr (
            .clk   (clk),
            .rst   (rst),
            .load  (lane_load),
            .seed  (seed[g*LFSR_W +: LFSR_W]),
            .step  (lane_step),
            .value (rnd[g*LFSR_W +: LFSR_W])
        );
    end

    // Lanes load on the same edge that issues the first read, so its address uses the fixed seeds.
    always_comb begin
        seed_fix = '0;
        for (int unsigned i = 0; i < NUM_LFSR; i++) begin
            seed_fix[i*LFSR_W +: LFSR_W] = lfsr_fix_seed(seed[i*LFSR_W +: LFSR_W]);
        end
    end

    assign rnd_d = DATA_W'(rnd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mode_n     = mode_q;
        num_n      = num_q;
        range_n    = range_q;
        din_n      = din_q;
        addr_n     = addr;
        dout_n     = dout;
        req_n      = 1'b0;
        wr_n       = wr;
        busy_n     = busy;
        done_n     = done;
        cnt_n      = upd_count;
        lane_load  = 1'b0;
        lane_step  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    mode_n    = mode;
                    num_n     = num_updates;
                    range_n   = range;
                    lane_load = 1'b1;
                    cnt_n     = '0;
                    if (num_updates == '0) begin
                        state_next = DONE;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                    end else begin
                        state_next = RD;
                        busy_n     = 1'b1;
                        req_n      = 1'b1;
                        wr_n       = 1'b0;
                        addr_n     = ADDR_W'(seed_fix) & range;
                    end
                end
            end
            RD: begin
                req_n = 1'b1;
                if (rdy) begin
                    din_n      = din;
                    req_n      = 1'b0;
                    state_next = MOD;
                end
            end
            MOD: begin
                case (mode_q)
                    MODE_XOR: dout_n = din_q ^ rnd_d;
                    MODE_ADD: dout_n = din_q + rnd_d;
                    default:  dout_n = din_q + DATA_W'(1);
                endcase
                req_n      = 1'b1;
                wr_n       = 1'b1;
                state_next = WR;
            end
            WR: begin
                req_n = 1'b1;
                if (rdy) begin
                    req_n      = 1'b0;
                    lane_step  = 1'b1;
                    cnt_n      = (upd_count == '1) ? upd_count : upd_count + CNT_W'(1);
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (upd_count == num_q) begin
                    state_next = DONE;
                    busy_n     = 1'b0;
                    done_n     = 1'b1;
                end else begin
                    state_next = RD;
                    req_n      = 1'b1;
                    wr_n       = 1'b0;
                    addr_n     = ADDR_W'(rnd) & range_q;
                end
            end
            DONE: begin
                if (!start) begin
                    state_next = IDLE;
                    done_n     = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= '0;
            num_q     <= '0;
            range_q   <= '0;
            din_q     <= '0;
            addr      <= '0;
            dout      <= '0;
            req       <= 1'b0;
            wr        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            upd_count <= '0;
        end else begin
            mode_q    <= mode_n;
            num_q     <= num_n;
            range_q   <= range_n;
            din_q     <= din_n;
            addr      <= addr_n;
            dout      <= dout_n;
            req       <= req_n;
            wr        <= wr_n;
            busy      <= busy_n;
            done      <= done_n;
            upd_count <= cnt_n;
        end
    end

endmodule

// File: tb/tb_gups_update_engine.sv
// Self-checking bench for gups_update_engine: memory responder plus behavioural address/data model.
module tb_gups_update_engine;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ADDR_W   = 64;
    localparam int unsigned NUM_LFSR = 4;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned MEM_N    = 8192;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic [CNT_W-1:0]  num_updates;
    logic [63:0]       seed;
    logic [ADDR_W-1:0] range;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic [DATA_W-1:0] din;
    logic              req, wr, rdy, busy, done;
    logic [CNT_W-1:0]  upd_count;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] mem [MEM_N];
    logic [15:0] lane [NUM_LFSR];
    logic [1:0]  m_mode;
    logic [63:0] m_range;
    logic [63:0] last_dout;

    always #5 clk = ~clk;

    gups_update_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_LFSR(NUM_LFSR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .num_updates(num_updates),
        .seed(seed), .range(range), .addr(addr), .dout(dout), .din(din),
        .req(req), .wr(wr), .rdy(rdy), .busy(busy), .done(done), .upd_count(upd_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] v);
        logic [15:0] s;
        s = v >> 1;
        if (v[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    function automatic logic [63:0] model_rnd();
        return {lane[3], lane[2], lane[1], lane[0]};
    endfunction

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (req === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk("req_timeout", 64'(req), 64'd1);
    endtask

    task automatic start_run(input logic [1:0] md, input logic [31:0] n,
                             input logic [63:0] sd, input logic [63:0] rg);
        @(negedge clk);
        mode = md; num_updates = n; seed = sd; range = rg; start = 1'b1;
        m_mode = md; m_range = rg;
        for (int i = 0; i < NUM_LFSR; i++) begin
            lane[i] = sd[16*i +: 16];
            if (lane[i] == 16'h0000) lane[i] = 16'h0001;
        end
        @(negedge clk);
        // Scramble control inputs: the engine must use the values latched at start.
        mode = 2'($urandom); num_updates = $urandom;
        seed = {$urandom, $urandom}; range = {$urandom, $urandom};
    endtask

    task automatic serve(input int n, input int rlat, input int wlat, input bit stray);
        logic [63:0] exp_a, exp_d, rv;
        logic [12:0] idx;
        bit ok;
        for (int k = 0; k < n; k++) begin
            rv    = model_rnd();
            exp_a = rv & m_range;
            idx   = exp_a[12:0];
            wait_req(ok);
            if (!ok) return;
            chk("rd_wr", 64'(wr), 64'd0);
            chk("rd_addr", addr, exp_a);
            chk("rd_addr_max", 64'(addr > 64'(MEM_N - 1)), 64'd0);
            chk("busy_run", 64'(busy), 64'd1);
            for (int c = 0; c < rlat; c++) begin
                @(negedge clk);
                chk("rd_hold_req", 64'(req), 64'd1);
                chk("rd_hold_addr", addr, exp_a);
            end
            din = mem[idx]; rdy = 1'b1;
            @(negedge clk);
            rdy = 1'b0; din = {$urandom, $urandom};
            chk("rd_req_drop", 64'(req), 64'd0);
            if (stray) begin
                rdy = 1'b1;
                @(negedge clk);
                rdy = 1'b0;
            end
            case (m_mode)
                2'd1:    exp_d = mem[idx] ^ rv;
                2'd2:    exp_d = mem[idx] + rv;
                default: exp_d = mem[idx] + 64'd1;
            endcase
            wait_req(ok);
            if (!ok) return;
            chk("wr_wr", 64'(wr), 64'd1);
            chk("wr_addr", addr, exp_a);
            chk("wr_dout", dout, exp_d);
            last_dout = dout;
            for (int c = 0; c < wlat; c++) begin
                @(negedge clk);
                chk("wr_hold_req", 64'(req), 64'd1);
                chk("wr_hold_addr", addr, exp_a);
                chk("wr_hold_dout", dout, exp_d);
            end
            rdy = 1'b1;
            @(negedge clk);
            rdy = 1'b0;
            mem[idx] = exp_d;
            for (int i = 0; i < NUM_LFSR; i++) lane[i] = model_step(lane[i]);
            chk("wr_req_drop", 64'(req), 64'd0);
            chk("upd_count", 64'(upd_count), 64'(k + 1));
            if (stray) begin
                rdy = 1'b1;
                @(negedge clk);
                rdy = 1'b0;
            end
        end
    endtask

    task automatic finish_run(input logic [31:0] n);
        for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
        chk("done_set", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_req", 64'(req), 64'd0);
        chk("done_count", 64'(upd_count), 64'(n));
        repeat (2) @(negedge clk);
        chk("done_hold", 64'(done), 64'd1);
        start = 1'b0;
        @(negedge clk);
        chk("done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        logic [63:0] sd, rv;
        logic [12:0] idx;
        bit ok;
        int saw_req;

        for (int i = 0; i < MEM_N; i++) mem[i] = {$urandom, $urandom};
        rst = 1'b1; start = 1'b0; mode = '0; num_updates = '0; seed = '0;
        range = '0; din = '0; rdy = 1'b0;
        #1 rst = 1'b0;

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_req", 64'(req), 64'd0);
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_count", 64'(upd_count), 64'd0);
        chk("rst_addr", addr, 64'd0);
        chk("rst_dout", dout, 64'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_req", 64'(req), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);

        // Increment mode, long run
        start_run(2'd0, 1000, {$urandom, $urandom}, 64'h1FFF);
        serve(1000, 2, 2, 1'b0);
        finish_run(1000);

        // Reserved mode behaves as increment
        start_run(2'd3, 10, {$urandom, $urandom}, 64'h1FFF);
        serve(10, 1, 1, 1'b0);
        finish_run(10);

        // XOR mode, all-zero seeds
        start_run(2'd1, 20, 64'h0, 64'h1FFF);
        wait_req(ok);
        chk("zero_seed_addr", addr, 64'h0001_0001_0001_0001 & 64'h1FFF);
        serve(20, 2, 2, 1'b0);
        finish_run(20);

        // Add mode, slow writes, stray rdy pulses
        start_run(2'd2, 30, {$urandom, $urandom}, 64'h0F3C);
        serve(30, 1, 5, 1'b1);
        finish_run(30);

        // Add mode wrap-around to zero
        sd = {$urandom, $urandom};
        rv = sd;
        for (int i = 0; i < NUM_LFSR; i++) if (rv[16*i +: 16] == 16'h0) rv[16*i +: 16] = 16'h0001;
        idx = rv[12:0];
        mem[idx] = 64'd0 - rv;
        start_run(2'd2, 1, sd, 64'h1FFF);
        serve(1, 2, 2, 1'b0);
        chk("wrap_dout", last_dout, 64'd0);
        finish_run(1);

        // Zero updates: done quickly, no request
        start_run(2'd0, 0, {$urandom, $urandom}, 64'h1FFF);
        chk("zero_done", 64'(done), 64'd1);
        saw_req = 0;
        repeat (3) begin
            if (req !== 1'b0) saw_req++;
            @(negedge clk);
        end
        chk("zero_no_req", 64'(saw_req), 64'd0);
        finish_run(0);

        // Reset while a write waits for rdy, then replay the same sequence
        sd = {$urandom, $urandom};
        start_run(2'd1, 50, sd, 64'h1FFF);
        serve(3, 2, 2, 1'b0);
        wait_req(ok);
        din = mem[model_rnd() & 64'h1FFF]; rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        wait_req(ok);
        chk("abort_in_wr", 64'(wr), 64'd1);
        #2 rst = 1'b0; start = 1'b0;
        #1;
        chk("abort_req", 64'(req), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_wr", 64'(wr), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        start_run(2'd1, 8, sd, 64'h1FFF);
        serve(8, 2, 3, 1'b0);
        finish_run(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
